// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART.
//   uart_state_e             : common TX/RX frame state encoding
//   DEFAULT_CLOCKS_PER_PULSE : 50 MHz clock at 9600 baud
//   MAX_DATA_WIDTH           : widest supported frame payload
//   calc_parity()            : parity bit for a payload
package uart_pkg;

    localparam int DEFAULT_CLOCKS_PER_PULSE = 5208;
    localparam int MAX_DATA_WIDTH           = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Payloads narrower than MAX_DATA_WIDTH are zero-extended by the caller.
    // Zero padding does not change an XOR reduction, so one width fits all
    // frame sizes. Even parity: XOR of the data bits. Odd parity: its inverse.
    function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                         input logic                      odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst : clock, asynchronous active-high reset
//   push/din : write din when push and there is room (a pop in the same cycle
//              also makes room)
//   pop      : drop the head entry; ignored while empty
//   full     : DEPTH entries stored
//   empty    : no entries stored
//   dout     : head entry, forced to zero while empty
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             do_push_s;
    logic             do_pop_s;

    // The extra pointer bit tells full from empty when the indices match.
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign dout      = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];

    // Read and write pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Storage array; contents are only visible through dout when non-empty.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_buffered.sv
// FIFO-buffered UART: TX and RX on one clock, each side behind its own FIFO.
//   clk, rst            : clock, asynchronous active-high reset
//   tx_data/tx_valid    : byte to send, pushed when tx_valid && tx_ready
//   tx_ready            : TX FIFO not full
//   tx                  : serial output, idle high
//   tx_busy             : TX FIFO non-empty or frame in flight
//   rx                  : serial input, asynchronous to clk
//   rx_data/rx_valid    : head of RX FIFO, popped when rx_valid && rx_ready
//   rx_ready            : consumer ready
//   err_clr             : clears the sticky error flags
//   parity_err          : a frame with bad parity was dropped
//   frame_err           : a frame with a low stop bit was dropped
//   overrun             : a good frame was dropped because the RX FIFO was full
module uart_buffered
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = DEFAULT_CLOCKS_PER_PULSE,
    parameter int DATA_WIDTH       = 8,
    parameter int FIFO_DEPTH       = 16,
    parameter int PARITY_EN        = 0,
    parameter int PARITY_ODD       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx,
    output logic                  tx_busy,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    input  logic                  err_clr,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int              CW        = $clog2(CLOCKS_PER_PULSE);
    localparam int              BW        = 4;
    localparam logic [CW-1:0]   CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   BIT_LAST  = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [CW-1:0]   BIT_HALF  = CW'(CLOCKS_PER_PULSE / 2);
    localparam logic [BW-1:0]   IDX_ZERO  = 4'd0;
    localparam logic [BW-1:0]   IDX_ONE   = 4'd1;
    localparam logic [BW-1:0]   DATA_LAST = BW'(DATA_WIDTH - 1);
    localparam logic            PAR_EN_B  = (PARITY_EN != 32'sd0);
    localparam logic            PAR_ODD_B = (PARITY_ODD != 32'sd0);

    // ---------------------------------------------------------------- TX side
    uart_state_e           tx_state_r, tx_state_s;
    logic [CW-1:0]         tx_cnt_r, tx_cnt_s;
    logic [BW-1:0]         tx_bit_r, tx_bit_s;
    logic [DATA_WIDTH-1:0] tx_shift_r, tx_shift_s;
    logic                  tx_par_r, tx_par_s;
    logic                  tx_r, tx_line_s;
    logic                  tx_pop_s, tx_push_s;
    logic                  tx_full_s, tx_empty_s;
    logic [DATA_WIDTH-1:0] tx_dout_s;
    logic                  tx_done_s;

    assign tx_push_s = tx_valid && !tx_full_s;
    assign tx_ready  = !tx_full_s;
    assign tx        = tx_r;
    assign tx_busy   = (tx_state_r != ST_IDLE) || !tx_empty_s;
    assign tx_done_s = (tx_cnt_r == BIT_LAST);

    uart_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push_s),
        .din   (tx_data),
        .pop   (tx_pop_s),
        .full  (tx_full_s),
        .empty (tx_empty_s),
        .dout  (tx_dout_s)
    );

    // TX next-state: tx_line_s is the level for the following cycle, so every
    // bit change lands exactly on a bit-counter wrap.
    always_comb begin
        tx_state_s = tx_state_r;
        tx_cnt_s   = tx_cnt_r;
        tx_bit_s   = tx_bit_r;
        tx_shift_s = tx_shift_r;
        tx_par_s   = tx_par_r;
        tx_line_s  = tx_r;
        tx_pop_s   = 1'b0;
        case (tx_state_r)
            ST_IDLE: begin
                tx_cnt_s  = CNT_ZERO;
                tx_line_s = 1'b1;
                if (!tx_empty_s) begin
                    tx_pop_s   = 1'b1;
                    tx_state_s = ST_START;
                    tx_line_s  = 1'b0;
                end else begin
                    tx_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tx_done_s) begin
                    tx_cnt_s   = CNT_ZERO;
                    tx_state_s = ST_DATA;
                    tx_line_s  = tx_shift_r[0];
                end else begin
                    tx_cnt_s = tx_cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (tx_done_s) begin
                    tx_cnt_s = CNT_ZERO;
                    if (tx_bit_r == DATA_LAST) begin
                        if (PAR_EN_B) begin
                            tx_state_s = ST_PARITY;
                            tx_line_s  = tx_par_r;
                        end else begin
                            tx_state_s = ST_STOP;
                            tx_line_s  = 1'b1;
                        end
                    end else begin
                        tx_bit_s   = tx_bit_r + IDX_ONE;
                        tx_shift_s = {1'b0, tx_shift_r[DATA_WIDTH-1:1]};
                        tx_line_s  = tx_shift_r[1];
                    end
                end else begin
                    tx_cnt_s = tx_cnt_r + CNT_ONE;
                end
            end
            ST_PARITY: begin
                if (tx_done_s) begin
                    tx_cnt_s   = CNT_ZERO;
                    tx_state_s = ST_STOP;
                    tx_line_s  = 1'b1;
                end else begin
                    tx_cnt_s = tx_cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (tx_done_s) begin
                    tx_cnt_s = CNT_ZERO;
                    // Another byte waiting: start bit follows the stop bit directly.
                    if (!tx_empty_s) begin
                        tx_pop_s   = 1'b1;
                        tx_state_s = ST_START;
                        tx_line_s  = 1'b0;
                    end else begin
                        tx_state_s = ST_IDLE;
                        tx_line_s  = 1'b1;
                    end
                end else begin
                    tx_cnt_s = tx_cnt_r + CNT_ONE;
                end
            end
            default: begin
                tx_state_s = ST_IDLE;
                tx_cnt_s   = CNT_ZERO;
                tx_line_s  = 1'b1;
            end
        endcase
        if (tx_pop_s) begin
            tx_shift_s = tx_dout_s;
            tx_par_s   = calc_parity(MAX_DATA_WIDTH'(tx_dout_s), PAR_ODD_B);
            tx_bit_s   = IDX_ZERO;
        end else begin
            tx_bit_s = tx_bit_s;
        end
    end

    // TX state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_r <= ST_IDLE;
            tx_cnt_r   <= CNT_ZERO;
            tx_bit_r   <= IDX_ZERO;
            tx_shift_r <= {DATA_WIDTH{1'b0}};
            tx_par_r   <= 1'b0;
            tx_r       <= 1'b1;
        end else begin
            tx_state_r <= tx_state_s;
            tx_cnt_r   <= tx_cnt_s;
            tx_bit_r   <= tx_bit_s;
            tx_shift_r <= tx_shift_s;
            tx_par_r   <= tx_par_s;
            tx_r       <= tx_line_s;
        end
    end

    // ---------------------------------------------------------------- RX side
    logic                  rx_meta_r, rx_sync_r;
    uart_state_e           rx_state_r, rx_state_s;
    logic [CW-1:0]         rx_cnt_r, rx_cnt_s;
    logic [BW-1:0]         rx_bit_r, rx_bit_s;
    logic [DATA_WIDTH-1:0] rx_shift_r, rx_shift_s;
    logic                  rx_par_r, rx_par_s;
    logic                  rx_wait_r, rx_wait_s;
    logic                  rx_push_s, rx_pop_s;
    logic                  rx_full_s, rx_empty_s;
    logic                  parity_set_s, frame_set_s, overrun_set_s;
    logic                  parity_err_r, frame_err_r, overrun_r;

    assign rx_valid   = !rx_empty_s;
    assign rx_pop_s   = !rx_empty_s && rx_ready;
    assign parity_err = parity_err_r;
    assign frame_err  = frame_err_r;
    assign overrun    = overrun_r;

    uart_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push_s),
        .din   (rx_shift_r),
        .pop   (rx_pop_s),
        .full  (rx_full_s),
        .empty (rx_empty_s),
        .dout  (rx_data)
    );

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // RX next-state: start bit checked mid-bit, then one sample per bit period.
    always_comb begin
        rx_state_s    = rx_state_r;
        rx_cnt_s      = rx_cnt_r;
        rx_bit_s      = rx_bit_r;
        rx_shift_s    = rx_shift_r;
        rx_par_s      = rx_par_r;
        rx_wait_s     = rx_wait_r;
        rx_push_s     = 1'b0;
        parity_set_s  = 1'b0;
        frame_set_s   = 1'b0;
        overrun_set_s = 1'b0;
        case (rx_state_r)
            ST_IDLE: begin
                rx_cnt_s  = CNT_ZERO;
                rx_wait_s = 1'b0;
                if (!rx_sync_r) begin
                    rx_state_s = ST_START;
                end else begin
                    rx_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (rx_cnt_r == BIT_HALF) begin
                    rx_cnt_s = CNT_ZERO;
                    rx_bit_s = IDX_ZERO;
                    // High at mid start bit: a glitch, not a frame.
                    if (rx_sync_r) begin
                        rx_state_s = ST_IDLE;
                    end else begin
                        rx_state_s = ST_DATA;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_s   = CNT_ZERO;
                    rx_shift_s = {rx_sync_r, rx_shift_r[DATA_WIDTH-1:1]};
                    if (rx_bit_r == DATA_LAST) begin
                        rx_state_s = PAR_EN_B ? ST_PARITY : ST_STOP;
                    end else begin
                        rx_bit_s = rx_bit_r + IDX_ONE;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + CNT_ONE;
                end
            end
            ST_PARITY: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_s   = CNT_ZERO;
                    rx_par_s   = rx_sync_r;
                    rx_state_s = ST_STOP;
                end else begin
                    rx_cnt_s = rx_cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (rx_wait_r) begin
                    // After a framing error, hold off until the line is idle again.
                    if (rx_sync_r) begin
                        rx_wait_s  = 1'b0;
                        rx_state_s = ST_IDLE;
                    end else begin
                        rx_state_s = ST_STOP;
                    end
                end else if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_s = CNT_ZERO;
                    if (!rx_sync_r) begin
                        frame_set_s = 1'b1;
                        rx_wait_s   = 1'b1;
                    end else if (PAR_EN_B &&
                                 (rx_par_r != calc_parity(MAX_DATA_WIDTH'(rx_shift_r), PAR_ODD_B))) begin
                        parity_set_s = 1'b1;
                        rx_state_s   = ST_IDLE;
                    end else if (rx_full_s && !rx_pop_s) begin
                        overrun_set_s = 1'b1;
                        rx_state_s    = ST_IDLE;
                    end else begin
                        rx_push_s  = 1'b1;
                        rx_state_s = ST_IDLE;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + CNT_ONE;
                end
            end
            default: begin
                rx_state_s = ST_IDLE;
                rx_cnt_s   = CNT_ZERO;
                rx_wait_s  = 1'b0;
            end
        endcase
    end

    // RX state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_r <= ST_IDLE;
            rx_cnt_r   <= CNT_ZERO;
            rx_bit_r   <= IDX_ZERO;
            rx_shift_r <= {DATA_WIDTH{1'b0}};
            rx_par_r   <= 1'b0;
            rx_wait_r  <= 1'b0;
        end else begin
            rx_state_r <= rx_state_s;
            rx_cnt_r   <= rx_cnt_s;
            rx_bit_r   <= rx_bit_s;
            rx_shift_r <= rx_shift_s;
            rx_par_r   <= rx_par_s;
            rx_wait_r  <= rx_wait_s;
        end
    end

    // Sticky error flags; a new error wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            parity_err_r <= parity_set_s  | (parity_err_r & ~err_clr);
            frame_err_r  <= frame_set_s   | (frame_err_r  & ~err_clr);
            overrun_r    <= overrun_set_s | (overrun_r    & ~err_clr);
        end
    end

endmodule
